bp_update_queue: RTL and testbench
==================================

# bp_update_queue

Tracks every conditional branch between fetch and resolution: records the pattern index and direction the global branch predictor used in IF, then issues exactly one in-order predictor update per resolved branch in MEM. It sits between the fetch stage, the MEM-stage branch resolver and the pattern-history-table predictor. It drives the predictor's `update`, `MEM_pattern_used` and `branch_result` inputs, and flags mispredictions.

## Interface
- `PATTERN_BITS`, 4, width of the history pattern index; matches the predictor.
- `DEPTH`, 4, number of in-flight branch entries; power of two, at least 2.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_push` in 1: IF fetched a branch; record `if_pattern` and `if_pred`.
- `if_pattern` in PATTERN_BITS: `IF_pattern_used` from the predictor.
- `if_pred` in 1: predicted direction, 1 = taken.
- `full` out 1: no free entry; IF must stall branch fetch.
- `mem_resolve` in 1: the oldest outstanding branch resolves this cycle.
- `mem_taken` in 1: actual direction of the resolving branch.
- `flush` in 1: external pipeline flush; discard all entries.
- `upd_valid` out 1: predictor `update` strobe.
- `upd_pattern` out PATTERN_BITS: predictor `MEM_pattern_used`.
- `upd_taken` out 1: predictor `branch_result`.
- `mispredict` out 1: registered mismatch flag for the resolved branch.
- `count` out $clog2(DEPTH)+1: number of occupied entries.

## Operation
- Circular FIFO with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH. A separate occupancy counter distinguishes full from empty.
- Push (`if_push`):
  - Writes {`if_pattern`, `if_pred`} at tail.
  - Ignored when `full` is high and no pop occurs in the same cycle.
  - Dropped entirely on any cycle with a flush or a mispredicting resolve.
- Resolve (`mem_resolve`) with `count` > 0 pops the head entry and registers:
  - `upd_valid` = 1
  - `upd_pattern` = head pattern
  - `upd_taken` = `mem_taken`
  - `mispredict` = (head pred != `mem_taken`)
- Resolve while empty is ignored: no update is issued and `mispredict` stays 0.
- Mispredicting resolve: the popped entry is updated normally. All younger entries are discarded on the same edge (they are wrong-path), leaving `count` = 0.
- `flush` sets `count` to 0 and `head` = `tail` = 0. If a resolve arrives in the same cycle, it is still processed and its update is issued.
- Simultaneous push and pop when full: both are accepted and `count` is unchanged.
- `full` = (`count` == DEPTH), combinational from registered state.

## Timing
- Reset values are all 0: pointers, `count`, `upd_valid`, `upd_pattern`, `upd_taken`, `mispredict`, and the statistics counters. `full` = 0.
- Resolve-to-update latency is 1 cycle. `upd_valid` and `mispredict` are single-cycle pulses.
- Back-to-back resolves produce back-to-back update pulses. At most one update per cycle.
- A pushed entry can be resolved in the next cycle or later, never in the push cycle.
- Reset asserted mid-operation clears all state immediately. No update pulse follows reset release.

## Configuration
- `BP_UPDATE_QUEUE_STATS_EN`: adds outputs `stat_resolved` [31:0] and `stat_mispredict` [31:0].
  - `stat_resolved` increments on each valid resolve; `stat_mispredict` increments on each mispredict.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Without the macro, these ports and counters do not exist and the behaviour is otherwise identical.

## Structure
- Shared package `rv32i_types`:
  - `bp_entry_t` packed struct {pattern [PATTERN_BITS-1:0], pred}.
  - Constant `BP_QUEUE_DEPTH` = 4.
- Sub-module `bp_entry_fifo` holds the storage array, pointers and count, with push/pop/clear ports. `bp_update_queue` adds resolve, mispredict and update registering, plus stats.

## Test plan
- Push patterns 3, 5, 9 with preds 1, 0, 1, then resolve taken = 1, 0, 1 → three consecutive `upd_valid` pulses with patterns 3, 5, 9, each one cycle after its resolve; `mispredict` stays 0.
- Push 4 entries → `full` = 1 and `count` = 4. A 5th push is ignored. A push plus resolve in the same cycle keeps `count` = 4 and the new entry appears at the tail after wrap-around.
- Push pattern 2 pred 1 and pattern 7 pred 0, then resolve with taken = 0 → `upd_pattern` = 2, `upd_taken` = 0, `mispredict` = 1, `count` = 0; a later resolve yields no update.
- Resolve with the queue empty → `upd_valid` stays 0 and `mispredict` stays 0.
- Push 2 entries, then assert `flush` together with a resolve (taken = 1) and a push → update issued for the head entry, `count` = 0, pushed entry dropped.
- Deassert `rst_n` mid-stream with 3 entries queued → all outputs 0 asynchronously; after release, `count` = 0 and no spurious `upd_valid`. With `BP_UPDATE_QUEUE_STATS_EN`, both statistics counters read 0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types and constants for the branch-predictor update queue.
package rv32i_types;

  localparam int unsigned BP_PATTERN_BITS = 4;
  localparam int unsigned BP_QUEUE_DEPTH  = 4;

  typedef struct packed {
    logic [BP_PATTERN_BITS-1:0] pattern;
    logic                       pred;
  } bp_entry_t;

endpackage

// File: rtl/bp_entry_fifo.sv
// Circular entry store with head/tail pointers and an occupancy counter.
// Clear wins over push; a pop while full frees the slot that a same-cycle push takes.
module bp_entry_fifo
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH   = BP_QUEUE_DEPTH,
  parameter type         entry_t = bp_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  input  logic                       clear,
  output entry_t                     head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            pop_ok;
  logic            push_ok;

  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[head_q];

  always_comb begin
    pop_ok  = pop && (count_q != '0);
    push_ok = push && !clear && (!full || pop_ok);
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[tail_q] = push_data;
    end
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so the increment wraps modulo DEPTH.
      head_d  = head_q + PW'(pop_ok);
      tail_d  = tail_q + PW'(push_ok);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bp_update_queue.sv
// In-order predictor update queue between IF and MEM; flags mispredictions.
// Optional statistics counters are enabled by defining BP_UPDATE_QUEUE_STATS_EN.
module bp_update_queue
  import rv32i_types::*;
#(
  parameter int unsigned PATTERN_BITS = BP_PATTERN_BITS,
  parameter int unsigned DEPTH        = BP_QUEUE_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       if_push,
  input  logic [PATTERN_BITS-1:0]    if_pattern,
  input  logic                       if_pred,
  output logic                       full,
  input  logic                       mem_resolve,
  input  logic                       mem_taken,
  input  logic                       flush,
  output logic                       upd_valid,
  output logic [PATTERN_BITS-1:0]    upd_pattern,
  output logic                       upd_taken,
  output logic                       mispredict,
  output logic [$clog2(DEPTH):0]     count
`ifdef BP_UPDATE_QUEUE_STATS_EN
  ,
  output logic [31:0]                stat_resolved,
  output logic [31:0]                stat_mispredict
`endif
);

  typedef struct packed {
    logic [PATTERN_BITS-1:0] pattern;
    logic                    pred;
  } entry_t;

  entry_t                  push_entry;
  entry_t                  head_entry;
  logic                    resolve_ok;
  logic                    mis_now;
  logic                    clear;

  logic                    upd_valid_q, upd_valid_d;
  logic [PATTERN_BITS-1:0] upd_pattern_q, upd_pattern_d;
  logic                    upd_taken_q, upd_taken_d;
  logic                    mispredict_q, mispredict_d;

  assign push_entry = '{pattern: if_pattern, pred: if_pred};

  // A mispredict discards all younger wrong-path entries the same way a flush does.
  assign resolve_ok = mem_resolve && (count != '0);
  assign mis_now    = resolve_ok && (head_entry.pred != mem_taken);
  assign clear      = flush || mis_now;

  bp_entry_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (if_push),
    .push_data (push_entry),
    .pop       (resolve_ok),
    .clear     (clear),
    .head_data (head_entry),
    .count     (count),
    .full      (full)
  );

  always_comb begin
    upd_valid_d   = resolve_ok;
    upd_pattern_d = upd_pattern_q;
    upd_taken_d   = upd_taken_q;
    mispredict_d  = mis_now;
    if (resolve_ok) begin
      upd_pattern_d = head_entry.pattern;
      upd_taken_d   = mem_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid_q   <= 1'b0;
      upd_pattern_q <= '0;
      upd_taken_q   <= 1'b0;
      mispredict_q  <= 1'b0;
    end else begin
      upd_valid_q   <= upd_valid_d;
      upd_pattern_q <= upd_pattern_d;
      upd_taken_q   <= upd_taken_d;
      mispredict_q  <= mispredict_d;
    end
  end

  assign upd_valid   = upd_valid_q;
  assign upd_pattern = upd_pattern_q;
  assign upd_taken   = upd_taken_q;
  assign mispredict  = mispredict_q;

`ifdef BP_UPDATE_QUEUE_STATS_EN
  logic [31:0] stat_resolved_q, stat_resolved_d;
  logic [31:0] stat_mispredict_q, stat_mispredict_d;

  always_comb begin
    stat_resolved_d   = stat_resolved_q;
    stat_mispredict_d = stat_mispredict_q;
    if (resolve_ok && (stat_resolved_q != '1)) begin
      stat_resolved_d = stat_resolved_q + 32'd1;
    end
    if (mis_now && (stat_mispredict_q != '1)) begin
      stat_mispredict_d = stat_mispredict_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_resolved_q   <= '0;
      stat_mispredict_q <= '0;
    end else begin
      stat_resolved_q   <= stat_resolved_d;
      stat_mispredict_q <= stat_mispredict_d;
    end
  end

  assign stat_resolved   = stat_resolved_q;
  assign stat_mispredict = stat_mispredict_q;
`endif

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed self-checking bench for bp_update_queue (default DEPTH=4, PATTERN_BITS=4).
module tb_bp_update_queue;

  logic       clk;
  logic       rst_n;
  logic       if_push;
  logic [3:0] if_pattern;
  logic       if_pred;
  logic       full;
  logic       mem_resolve;
  logic       mem_taken;
  logic       flush;
  logic       upd_valid;
  logic [3:0] upd_pattern;
  logic       upd_taken;
  logic       mispredict;
  logic [2:0] count;
`ifdef BP_UPDATE_QUEUE_STATS_EN
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispredict;
`endif

  int vectors;
  int miscompares;

  bp_update_queue #(
    .PATTERN_BITS (4),
    .DEPTH        (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_push     (if_push),
    .if_pattern  (if_pattern),
    .if_pred     (if_pred),
    .full        (full),
    .mem_resolve (mem_resolve),
    .mem_taken   (mem_taken),
    .flush       (flush),
    .upd_valid   (upd_valid),
    .upd_pattern (upd_pattern),
    .upd_taken   (upd_taken),
    .mispredict  (mispredict),
    .count       (count)
`ifdef BP_UPDATE_QUEUE_STATS_EN
    ,
    .stat_resolved   (stat_resolved),
    .stat_mispredict (stat_mispredict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    if_push     = 1'b0;
    if_pattern  = 4'd0;
    if_pred     = 1'b0;
    mem_resolve = 1'b0;
    mem_taken   = 1'b0;
    flush       = 1'b0;
  endtask

  // Apply the currently driven inputs on one rising edge, then return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic push(input logic [3:0] pat, input logic pred);
    if_push    = 1'b1;
    if_pattern = pat;
    if_pred    = pred;
    tick();
  endtask

  task automatic check_upd(input string name, input logic v, input logic [3:0] pat,
                           input logic tk, input logic mis);
    vectors++;
    if (upd_valid !== v || mispredict !== mis ||
        (v && (upd_pattern !== pat || upd_taken !== tk))) begin
      miscompares++;
      $display("FAIL %s: got valid=%b pat=%0d taken=%b mis=%b, want valid=%b pat=%0d taken=%b mis=%b",
               name, upd_valid, upd_pattern, upd_taken, mispredict, v, pat, tk, mis);
    end
  endtask

  task automatic check_count(input string name, input logic [2:0] c, input logic f);
    vectors++;
    if (count !== c || full !== f) begin
      miscompares++;
      $display("FAIL %s: got count=%0d full=%b, want count=%0d full=%b", name, count, full, c, f);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (count !== 3'd0 || full !== 1'b0 || upd_valid !== 1'b0 || upd_pattern !== 4'd0 ||
        upd_taken !== 1'b0 || mispredict !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got count=%0d full=%b valid=%b pat=%0d taken=%b mis=%b, want all 0",
               count, full, upd_valid, upd_pattern, upd_taken, mispredict);
    end
  endtask

  task automatic test_in_order();
    push(4'd3, 1'b1);
    push(4'd5, 1'b0);
    push(4'd9, 1'b1);
    check_count("in_order_count3", 3'd3, 1'b0);
    mem_resolve = 1'b1; mem_taken = 1'b1; tick();
    check_upd("in_order_upd0", 1'b1, 4'd3, 1'b1, 1'b0);
    mem_resolve = 1'b1; mem_taken = 1'b0; tick();
    check_upd("in_order_upd1", 1'b1, 4'd5, 1'b0, 1'b0);
    mem_resolve = 1'b1; mem_taken = 1'b1; tick();
    check_upd("in_order_upd2", 1'b1, 4'd9, 1'b1, 1'b0);
    tick();
    check_upd("in_order_idle", 1'b0, 4'd0, 1'b0, 1'b0);
    check_count("in_order_empty", 3'd0, 1'b0);
  endtask

  task automatic test_full_wrap();
    logic [3:0] exp_pat [4];
    exp_pat[0] = 4'd2; exp_pat[1] = 4'd3; exp_pat[2] = 4'd4; exp_pat[3] = 4'd6;
    push(4'd1, 1'b1);
    push(4'd2, 1'b1);
    push(4'd3, 1'b1);
    push(4'd4, 1'b1);
    check_count("full_after4", 3'd4, 1'b1);
    push(4'd5, 1'b1);
    check_count("full_push_ignored", 3'd4, 1'b1);
    if_push = 1'b1; if_pattern = 4'd6; if_pred = 1'b1;
    mem_resolve = 1'b1; mem_taken = 1'b1;
    tick();
    check_upd("full_push_pop_upd", 1'b1, 4'd1, 1'b1, 1'b0);
    check_count("full_push_pop_count", 3'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      mem_resolve = 1'b1; mem_taken = 1'b1; tick();
      check_upd($sformatf("full_drain%0d", i), 1'b1, exp_pat[i], 1'b1, 1'b0);
    end
    check_count("full_drained", 3'd0, 1'b0);
  endtask

  task automatic test_mispredict();
    push(4'd2, 1'b1);
    push(4'd7, 1'b0);
    mem_resolve = 1'b1; mem_taken = 1'b0; tick();
    check_upd("mis_upd", 1'b1, 4'd2, 1'b0, 1'b1);
    check_count("mis_count", 3'd0, 1'b0);
    mem_resolve = 1'b1; mem_taken = 1'b0; tick();
    check_upd("mis_later_resolve", 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_empty_resolve();
    mem_resolve = 1'b1; mem_taken = 1'b1; tick();
    check_upd("empty_resolve_taken", 1'b0, 4'd0, 1'b0, 1'b0);
    mem_resolve = 1'b1; mem_taken = 1'b0; tick();
    check_upd("empty_resolve_nt", 1'b0, 4'd0, 1'b0, 1'b0);
    check_count("empty_resolve_count", 3'd0, 1'b0);
  endtask

  task automatic test_flush();
    push(4'd10, 1'b1);
    push(4'd11, 1'b1);
    flush = 1'b1; mem_resolve = 1'b1; mem_taken = 1'b1;
    if_push = 1'b1; if_pattern = 4'd12; if_pred = 1'b0;
    tick();
    check_upd("flush_resolve_upd", 1'b1, 4'd10, 1'b1, 1'b0);
    check_count("flush_count", 3'd0, 1'b0);
    push(4'd13, 1'b0);
    check_count("flush_repush_count", 3'd1, 1'b0);
    mem_resolve = 1'b1; mem_taken = 1'b0; tick();
    check_upd("flush_repush_upd", 1'b1, 4'd13, 1'b0, 1'b0);
  endtask

`ifdef BP_UPDATE_QUEUE_STATS_EN
  task automatic test_stats();
    // 3 in-order + 5 full/wrap + 1 mispredict + 2 flush-test resolves; 1 mispredict.
    vectors++;
    if (stat_resolved !== 32'd11 || stat_mispredict !== 32'd1) begin
      miscompares++;
      $display("FAIL stats_accum: got resolved=%0d mispredict=%0d, want resolved=11 mispredict=1",
               stat_resolved, stat_mispredict);
    end
  endtask
`endif

  task automatic test_reset_mid();
    push(4'd1, 1'b1);
    push(4'd2, 1'b0);
    if_push = 1'b1; if_pattern = 4'd3; if_pred = 1'b1;
    mem_resolve = 1'b1; mem_taken = 1'b1;
    tick();
    check_upd("rstmid_pre_upd", 1'b1, 4'd1, 1'b1, 1'b0);
    push(4'd4, 1'b1);
    check_count("rstmid_pre_count", 3'd3, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (count !== 3'd0 || full !== 1'b0 || upd_valid !== 1'b0 || upd_pattern !== 4'd0 ||
        upd_taken !== 1'b0 || mispredict !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_async: got count=%0d valid=%b pat=%0d taken=%b mis=%b, want all 0",
               count, upd_valid, upd_pattern, upd_taken, mispredict);
    end
`ifdef BP_UPDATE_QUEUE_STATS_EN
    vectors++;
    if (stat_resolved !== 32'd0 || stat_mispredict !== 32'd0) begin
      miscompares++;
      $display("FAIL rstmid_stats: got resolved=%0d mispredict=%0d, want 0 0",
               stat_resolved, stat_mispredict);
    end
`endif
    mem_resolve = 1'b1; mem_taken = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    idle_inputs();
    tick();
    check_upd("rstmid_post_upd", 1'b0, 4'd0, 1'b0, 1'b0);
    check_count("rstmid_post_count", 3'd0, 1'b0);
    mem_resolve = 1'b1; mem_taken = 1'b1; tick();
    check_upd("rstmid_post_resolve", 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    test_reset();
    test_in_order();
    test_full_wrap();
    test_mispredict();
    test_empty_resolve();
    test_flush();
`ifdef BP_UPDATE_QUEUE_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
